// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decoded control and operands from ID,
// supports stall (hold) and flush (bubble), and counts inserted bubbles.
module id_ex_register #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [31:0]       RSdata_i,
    input  logic [31:0]       RTdata_i,
    input  logic [15:0]       imm_i,
    input  logic [4:0]        RSaddr_i,
    input  logic [4:0]        RTaddr_i,
    input  logic [4:0]        RDaddr_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic              RegDst_o,
    output logic [1:0]        ALUOp_o,
    output logic [31:0]       RSdata_o,
    output logic [31:0]       RTdata_o,
    output logic [31:0]       imm_o,
    output logic [4:0]        RSaddr_o,
    output logic [4:0]        RTaddr_o,
    output logic [4:0]        RDaddr_o,
    output logic [5:0]        funct_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned FUNCT_W = 6;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [ADDR_W-1:0] rs_addr;
        logic [ADDR_W-1:0] rt_addr;
        logic [ADDR_W-1:0] rd_addr;
    } data_t;

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    data_t            data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bubble_c;

    // State register: everything clears asynchronously, including held contents.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
            ctrl_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: flush beats stall beats load; flush writes constants so X inputs cannot leak.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        bubble_c = 1'b0;

        if (flush_i) begin
            state_d  = EMPTY;
            ctrl_d   = '0;
            data_d   = '0;
            bubble_c = 1'b1;
        end else if (!stall_i) begin
            data_d.rs_data = RSdata_i;
            data_d.rt_data = RTdata_i;
            data_d.imm     = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
            data_d.rs_addr = RSaddr_i;
            data_d.rt_addr = RTaddr_i;
            data_d.rd_addr = RDaddr_i;
            if (valid_i) begin
                state_d           = FULL;
                ctrl_d.reg_write  = RegWrite_i;
                ctrl_d.mem_to_reg = MemtoReg_i;
                ctrl_d.mem_read   = MemRead_i;
                ctrl_d.mem_write  = MemWrite_i;
                ctrl_d.alu_src    = ALUSrc_i;
                ctrl_d.reg_dst    = RegDst_i;
                ctrl_d.alu_op     = ALUOp_i;
            end else begin
                state_d  = EMPTY;
                ctrl_d   = '0;
                bubble_c = 1'b1;
            end
        end

        if (bubble_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign RegWrite_o   = ctrl_q.reg_write;
    assign MemtoReg_o   = ctrl_q.mem_to_reg;
    assign MemRead_o    = ctrl_q.mem_read;
    assign MemWrite_o   = ctrl_q.mem_write;
    assign ALUSrc_o     = ctrl_q.alu_src;
    assign RegDst_o     = ctrl_q.reg_dst;
    assign ALUOp_o      = ctrl_q.alu_op;
    assign RSdata_o     = data_q.rs_data;
    assign RTdata_o     = data_q.rt_data;
    assign imm_o        = data_q.imm;
    assign RSaddr_o     = data_q.rs_addr;
    assign RTaddr_o     = data_q.rt_addr;
    assign RDaddr_o     = data_q.rd_addr;
    assign funct_o      = data_q.imm[FUNCT_W-1:0];
    assign valid_o      = (state_q == FULL);
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: load, stall, flush, invalid slot,
// counter saturation and asynchronous reset.
module tb_id_ex_register;

    localparam int unsigned CNT_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              stall_i, flush_i, valid_i;
    logic              RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i;
    logic [1:0]        ALUOp_i;
    logic [31:0]       RSdata_i, RTdata_i;
    logic [15:0]       imm_i;
    logic [4:0]        RSaddr_i, RTaddr_i, RDaddr_i;
    logic              RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o;
    logic [1:0]        ALUOp_o;
    logic [31:0]       RSdata_o, RTdata_o, imm_o;
    logic [4:0]        RSaddr_o, RTaddr_o, RDaddr_o;
    logic [5:0]        funct_o;
    logic              valid_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    id_ex_register #(.CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o),
        .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .imm_o(imm_o),
        .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .RDaddr_o(RDaddr_o),
        .funct_o(funct_o), .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 0; flush_i = 0; valid_i = 0;
        RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0; ALUSrc_i = 0; RegDst_i = 0;
        ALUOp_i = 0; RSdata_i = 0; RTdata_i = 0; imm_i = 0; RSaddr_i = 0; RTaddr_i = 0; RDaddr_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, ALUOp_o}), 64'd0);
        check({tag, "_data"}, 64'(RSdata_o | RTdata_o | imm_o), 64'd0);
        check({tag, "_addr"}, 64'({RSaddr_o, RTaddr_o, RDaddr_o, funct_o}), 64'd0);
        check({tag, "_valid"}, 64'(valid_o), 64'd0);
    endtask

    initial begin
        clear_inputs();
        rst_i = 1'b0;
        RSdata_i = 32'hDEAD_BEEF; valid_i = 1; RegWrite_i = 1;
        tick();
        check_all_zero("reset");
        check("reset_cnt", 64'(bubble_cnt_o), 64'd0);
        #3 rst_i = 1'b1;
        clear_inputs();

        // Load
        valid_i = 1; RegWrite_i = 1; ALUOp_i = 2'b01; ALUSrc_i = 1;
        RSdata_i = 32'h0000_0005; imm_i = 16'hFFFC; RTaddr_i = 5'd9;
        tick();
        check("load_regwrite", 64'(RegWrite_o), 64'd1);
        check("load_aluop", 64'(ALUOp_o), 64'd1);
        check("load_alusrc", 64'(ALUSrc_o), 64'd1);
        check("load_memwrite", 64'(MemWrite_o), 64'd0);
        check("load_rsdata", 64'(RSdata_o), 64'h5);
        check("load_imm", 64'(imm_o), 64'hFFFF_FFFC);
        check("load_funct", 64'(funct_o), 64'h3C);
        check("load_rtaddr", 64'(RTaddr_o), 64'd9);
        check("load_valid", 64'(valid_o), 64'd1);
        check("load_cnt", 64'(bubble_cnt_o), 64'd0);

        // Positive immediate sign extension and R-type load
        clear_inputs();
        valid_i = 1; RegDst_i = 1; RegWrite_i = 1; RDaddr_i = 5'd3;
        RSdata_i = 32'hAAAA_5555; imm_i = 16'h7020;
        tick();
        check("rtype_rd", 64'(RDaddr_o), 64'd3);
        check("rtype_regdst", 64'(RegDst_o), 64'd1);
        check("rtype_imm", 64'(imm_o), 64'h0000_7020);
        check("rtype_funct", 64'(funct_o), 64'h20);

        // Stall for three cycles with changing inputs
        for (int i = 0; i < 3; i++) begin
            stall_i = 1; valid_i = i[0]; RegDst_i = 0; RegWrite_i = 0; MemWrite_i = 1;
            RDaddr_i = 5'(i + 10); RSdata_i = 32'h1111_0000 + 32'(i); imm_i = 16'h8001;
            tick();
            check("stall_rd", 64'(RDaddr_o), 64'd3);
            check("stall_ctrl", 64'({RegWrite_o, RegDst_o, MemWrite_o}), 64'b110);
            check("stall_rsdata", 64'(RSdata_o), 64'hAAAA_5555);
            check("stall_imm", 64'(imm_o), 64'h0000_7020);
            check("stall_valid", 64'(valid_o), 64'd1);
            check("stall_cnt", 64'(bubble_cnt_o), 64'd0);
        end

        // Flush beats stall, with X on the data inputs
        flush_i = 1; stall_i = 1; RSdata_i = 'x; RTdata_i = 'x; imm_i = 'x; RDaddr_i = 'x;
        tick();
        exp_cnt = 1;
        check_all_zero("flush");
        check("flush_cnt", 64'(bubble_cnt_o), 64'(exp_cnt));

        // Invalid slot: control suppressed, data still captured
        clear_inputs();
        valid_i = 0; RegWrite_i = 1; MemWrite_i = 1; RTdata_i = 32'h0000_1234;
        tick();
        exp_cnt = 2;
        check("inval_regwrite", 64'(RegWrite_o), 64'd0);
        check("inval_memwrite", 64'(MemWrite_o), 64'd0);
        check("inval_valid", 64'(valid_o), 64'd0);
        check("inval_rtdata", 64'(RTdata_o), 64'h1234);
        check("inval_cnt", 64'(bubble_cnt_o), 64'(exp_cnt));

        // Stall while empty does not count
        stall_i = 1;
        tick();
        check("stall_empty_cnt", 64'(bubble_cnt_o), 64'(exp_cnt));
        check("stall_empty_valid", 64'(valid_o), 64'd0);

        // Valid load does not count
        clear_inputs();
        valid_i = 1; MemRead_i = 1; MemtoReg_i = 1;
        tick();
        check("valid_ctrl", 64'({MemRead_o, MemtoReg_o}), 64'b11);
        check("valid_cnt", 64'(bubble_cnt_o), 64'(exp_cnt));

        // Saturation across 20 flushes
        clear_inputs();
        flush_i = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_cnt < 15) exp_cnt++;
            check("sat_cnt", 64'(bubble_cnt_o), 64'(exp_cnt));
        end
        check("sat_final", 64'(bubble_cnt_o), 64'hF);
        flush_i = 0; valid_i = 0;
        tick();
        check("sat_hold", 64'(bubble_cnt_o), 64'hF);

        // Asynchronous reset between edges while FULL
        clear_inputs();
        valid_i = 1; RegWrite_i = 1; RSdata_i = 32'hCAFE_F00D; imm_i = 16'h1234;
        tick();
        check("pre_rst_valid", 64'(valid_o), 64'd1);
        #2 rst_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("async_rst_cnt", 64'(bubble_cnt_o), 64'd0);
        flush_i = 1; stall_i = 1;
        tick();
        tick();
        check_all_zero("rst_hold");
        check("rst_hold_cnt", 64'(bubble_cnt_o), 64'd0);

        // First edge after release is a normal load
        #3 rst_i = 1'b1;
        flush_i = 0; stall_i = 0;
        tick();
        check("post_rst_valid", 64'(valid_o), 64'd1);
        check("post_rst_rsdata", 64'(RSdata_o), 64'hCAFE_F00D);
        check("post_rst_cnt", 64'(bubble_cnt_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
